btn_debounce_cond: RTL

Input conditioner for one mechanical pushbutton or switch, placed directly upstream of the single-bit Avalon PIO input port. It synchronises the raw pin into `clk`, debounces it with a counter-based state machine, and drives the clean level into the PIO `in_port`. It also provides one-cycle rise/fall pulses and a saturating bounce counter for bring-up diagnostics.

---
 rtl/btn_debounce_cond.sv | 95 +++++++++
 1 files changed

// File: rtl/btn_debounce_cond.sv
// Pushbutton conditioner: 2-flop synchroniser, counter-based debounce FSM, edge pulses
// and a saturating bounce counter. Define BTN_DEBOUNCE_INVERT_EN for active-low pads.
module btn_debounce_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic [7:0] bounce_cnt
);

  typedef enum logic [0:0] {StStable, StPending} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_in;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  state_e           state_q;

`ifdef BTN_DEBOUNCE_INVERT_EN
  assign btn_in = ~btn_raw;
`else
  assign btn_in = btn_raw;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StStable;
      cnt_q      <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state_q)
        StStable: begin
          if (sync2_q != level) begin
            if (DEBOUNCE_CYCLES == 1) begin
              level   <= ~level;
              rise    <= ~level;
              fall    <= level;
              cnt_q   <= '0;
            end else begin
              state_q <= StPending;
              cnt_q   <= CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        StPending: begin
          if (sync2_q == level) begin
            // Input fell back before reaching the threshold: count it as a bounce.
            state_q <= StStable;
            cnt_q   <= '0;
            if (bounce_cnt != 8'hFF) begin
              bounce_cnt <= bounce_cnt + 8'd1;
            end
          end else if (cnt_q == CntLast) begin
            level   <= ~level;
            rise    <= ~level;
            fall    <= level;
            state_q <= StStable;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StStable;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
